instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the single-cycle RISC-V core, directly upstream of the control unit. Holds the program counter, issues word requests to instruction memory over a request/response interface of any latency, and presents one instruction with its PC and a valid flag to decode; `opcode` drives the control unit's `Opcode` input. Applies taken-branch redirects (control unit `branch` qualified by ALU `zero`), discards in-flight fetches, and buffers one response when decode stalls.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  one-cycle fetch request pulse
- `imem_addr`  out  32  fetch address, equals `pc`
- `imem_rvalid`  in  1  response valid, one cycle, ≥1 cycle after `imem_req`
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`
- `stall`  in  1  decode cannot accept; output must hold
- `branch`  in  1  from control unit, refers to the instruction at the output
- `zero`  in  1  ALU zero flag
- `branch_target`  in  32  redirect address
- `instr`  out  32  instruction to decode
- `instr_pc`  out  32  address of `instr`
- `instr_valid`  out  1  `instr` holds a live instruction
- `opcode`  out  7  `instr[6:0]` when `instr_valid`, else 7'b0
- `misaligned_err`  out  1  sticky: redirect to a non-word-aligned target

## Operation
- Registers: `pc` (next fetch address), output register (`instr`, `instr_pc`, `instr_valid`), one-entry hold buffer (word + PC + valid), `drop` flag, state.
- Consume: output consumed in any cycle with `instr_valid=1` and `stall=0`.
- Redirect: `take = instr_valid & branch & zero & ~stall`. On `take`: `pc<=branch_target`, `instr_valid<=0`, hold buffer cleared, `drop<=1` if a request is outstanding (state WAIT, or FETCH this cycle).
- FSM:
  - FETCH: `imem_req=1`, `imem_addr=pc`; next WAIT. A `take` here still issues the request; its response is dropped.
  - WAIT: `imem_req=0`; wait for `imem_rvalid`.
    - If `drop=1`: discard the word, clear `drop`, go to FETCH (new `pc`).
    - Else, if the output is empty or consumed this cycle: load the output with `imem_rdata` and `pc`, set `pc<=pc+4`, go to FETCH.
    - Else, output full and stalled: store the word and `pc` in the hold buffer, set `pc<=pc+4`, go to HOLD.
  - HOLD: no requests. When the output is consumed, move the hold buffer to the output and go to FETCH. A `take` clears the hold buffer and goes to FETCH.
  - HALT: entered on `take` with `branch_target[1:0]!=0`. Sets `misaligned_err`, `instr_valid=0`, no further requests. Leave only via reset.
- `imem_rvalid` outside WAIT is ignored.
- `pc+4` wraps modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
- `take` and `imem_rvalid` in the same WAIT cycle: the response is discarded and the next state is FETCH at `branch_target`.

## Timing
- Reset (asserted, async):
  - State FETCH, `pc=RESET_PC`.
  - `imem_req=0` while reset is asserted.
  - `imem_addr=RESET_PC`, `instr=0`, `instr_pc=0`, `instr_valid=0`, `opcode=0`, `misaligned_err=0`.
  - `drop=0`, hold buffer empty.
- First `imem_req` is in the first cycle after `reset` rises.
- Reset asserted mid-transfer returns to reset values immediately. Stale responses land outside WAIT and are ignored.
- With 1-cycle memory latency: request at cycle N, `instr_valid` at N+2. Steady throughput is one instruction per 2 cycles.
- Redirect: `take` at cycle N → `instr_valid=0` at N+1. The target's request is issued at N+1 if no request is outstanding, otherwise in the cycle after the dropped response.
- All outputs are registered except `imem_req` (decoded from state) and `opcode` (gated from registered `instr`/`instr_valid`).

## Test plan
- Reset sequencing: `RESET_PC`=0x100, memory returns 0x00000033 then 0x00000003 with 1-cycle latency → `imem_addr` 0x100 then 0x104; `instr_pc` 0x100 then 0x104; `opcode` 7'b0110011 then 7'b0000011.
- Stall/hold: `stall=1` for 6 cycles after the first instruction → `instr` stays 0x00000033, second word is held, no third request. On release: 0x104 word appears the next cycle, then a request to 0x108.
- Branch redirect: instruction at 0x104 with `branch=1`, `zero=1`, `branch_target`=0x200 while a request to 0x108 is in flight → the 0x108 response is dropped, next `instr_pc`=0x200. With `zero=0`, fetch continues at 0x108.
- Misaligned target: `take` with `branch_target`=0x202 → `misaligned_err=1`, `instr_valid=0`, no `imem_req` for 20 cycles, cleared only by reset.
- Wrap and latency: `RESET_PC`=0xFFFF_FFFC, 3-cycle memory latency → second fetch address 0x0000_0000, responses accepted only in WAIT.
- Async reset mid-WAIT: drop `reset` between request and response → outputs at reset values within the same cycle, then a clean restart at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word request at a time to instruction
// memory (any response latency) and presents one instruction to decode.
// Taken branches redirect the PC and squash in-flight fetches. One response
// can be parked in a hold buffer while decode stalls. A redirect to a
// non-word-aligned target halts fetch until reset.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic        misaligned_err
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] out_word_reg, out_word_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] hold_word_reg, hold_word_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic        hold_valid_reg, hold_valid_next;
    logic        drop_reg, drop_next;
    logic        err_reg, err_next;

    logic        consume;
    logic        take;
    logic        target_misaligned;
    logic [31:0] pc_plus4;

    // Decode takes the output word this cycle; a taken branch implies consumption.
    assign consume           = out_valid_reg & ~stall;
    assign take              = out_valid_reg & branch & zero & ~stall;
    assign target_misaligned = (branch_target[1:0] != 2'b00);
    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
    assign pc_plus4          = pc_reg + 32'd4;

    // Request is decoded from state; suppressed while reset is held low.
    assign imem_req       = (state_reg == S_FETCH) & reset;
    assign imem_addr      = pc_reg;
    assign instr          = out_word_reg;
    assign instr_pc       = out_pc_reg;
    assign instr_valid    = out_valid_reg;
    assign opcode         = out_valid_reg ? out_word_reg[6:0] : 7'b000_0000;
    assign misaligned_err = err_reg;

    // Next-state logic: redirect has priority over all normal state activity.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        out_word_next   = out_word_reg;
        out_pc_next     = out_pc_reg;
        out_valid_next  = out_valid_reg;
        hold_word_next  = hold_word_reg;
        hold_pc_next    = hold_pc_reg;
        hold_valid_next = hold_valid_reg;
        drop_next       = drop_reg;
        err_next        = err_reg;

        if (take) begin
            pc_next         = branch_target;
            out_valid_next  = 1'b0;
            hold_valid_next = 1'b0;
            if (target_misaligned) begin
                // Fetch stops for good; any in-flight response lands outside WAIT.
                state_next = S_HALT;
                err_next   = 1'b1;
                drop_next  = 1'b0;
            end else begin
                case (state_reg)
                    S_FETCH: begin
                        // The request still goes out this cycle; squash its response.
                        drop_next  = 1'b1;
                        state_next = S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            // Stale response arrives together with the redirect.
                            drop_next  = 1'b0;
                            state_next = S_FETCH;
                        end else begin
                            drop_next  = 1'b1;
                            state_next = S_WAIT;
                        end
                    end
                    default: begin
                        drop_next  = 1'b0;
                        state_next = S_FETCH;
                    end
                endcase
            end
        end else begin
            if (consume) begin
                out_valid_next = 1'b0;
            end
            case (state_reg)
                S_FETCH: begin
                    state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_reg) begin
                            drop_next  = 1'b0;
                            state_next = S_FETCH;
                        end else if (!out_valid_reg || consume) begin
                            out_word_next  = imem_rdata;
                            out_pc_next    = pc_reg;
                            out_valid_next = 1'b1;
                            pc_next        = pc_plus4;
                            state_next     = S_FETCH;
                        end else begin
                            // Output full and stalled: park the word.
                            hold_word_next  = imem_rdata;
                            hold_pc_next    = pc_reg;
                            hold_valid_next = 1'b1;
                            pc_next         = pc_plus4;
                            state_next      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        out_word_next   = hold_word_reg;
                        out_pc_next     = hold_pc_reg;
                        out_valid_next  = hold_valid_reg;
                        hold_valid_next = 1'b0;
                        state_next      = S_FETCH;
                    end
                end
                default: begin
                    state_next = S_HALT;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_FETCH;
            pc_reg         <= RESET_PC;
            out_word_reg   <= 32'h0000_0000;
            out_pc_reg     <= 32'h0000_0000;
            out_valid_reg  <= 1'b0;
            hold_word_reg  <= 32'h0000_0000;
            hold_pc_reg    <= 32'h0000_0000;
            hold_valid_reg <= 1'b0;
            drop_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            out_word_reg   <= out_word_next;
            out_pc_reg     <= out_pc_next;
            out_valid_reg  <= out_valid_next;
            hold_word_reg  <= hold_word_next;
            hold_pc_reg    <= hold_pc_next;
            hold_valid_reg <= hold_valid_next;
            drop_reg       <= drop_next;
            err_reg        <= err_next;
        end
    end

endmodule
